task_fifo_bank: RTL and testbench
=================================

TASK_FIFO_BANK -- requirements
Module: task_fifo_bank

Interface
REQ-001 Parameter PTW, default 16, payload data width.
REQ-002 Parameter LEVEL, default 4, number of RPU levels; one task FIFO per level.
REQ-003 Parameter TREE_NUM, default 4, number of virtual trees; TREE_NUM_BITS = $clog2(TREE_NUM).
REQ-004 Parameter DEPTH, default 8, entries per FIFO, power of two, minimum 2; LVL_BITS = $clog2(LEVEL) (minimum 1).
REQ-005 i_clk  input  1  the block's only clock; all state changes on its rising edge.
REQ-006 i_arst_n  input  1  asynchronous, active-low reset.
REQ-007 i_task_valid  input  1  ingress task offered.
REQ-008 o_task_ready  output  1  ingress task accepted when high together with i_task_valid.
REQ-009 i_task_level  input  LVL_BITS  destination level FIFO.
REQ-010 i_task_type  input  1  1 = push, 0 = pop.
REQ-011 i_task_treeId  input  TREE_NUM_BITS  target tree.
REQ-012 i_task_data  input  PTW  push payload; ignored and stored as zero for pop tasks.
REQ-013 i_pop_TaskFIFO  input  LEVEL  per-level dequeue request from the task distributor.
REQ-014 o_TaskFIFO_data  output  [PTW+TREE_NUM_BITS:0] x LEVEL  dequeued entry {type, treeId, data}.
REQ-015 o_TaskFIFO_empty  output  LEVEL  per-level FIFO empty.
REQ-016 o_fifo_count  output  $clog2(DEPTH+1) x LEVEL  per-level occupancy.
REQ-017 o_level_err  output  1  sticky flag: a task was addressed to a level >= LEVEL.

Function
REQ-018 o_task_ready SHALL equal !full[i_task_level] for legal levels and 1 for illegal levels; it SHALL depend only on registered occupancy.
REQ-019 An accepted legal task SHALL be written at the tail of FIFO i_task_level and SHALL increment its count at the next edge.
REQ-020 An accepted task with i_task_level >= LEVEL SHALL be dropped and SHALL set o_level_err at the next edge; o_level_err SHALL stay set until reset.
REQ-021 o_TaskFIFO_empty[i] SHALL be high exactly when count[i] == 0, using the registered count.
REQ-022 Read latency SHALL be one cycle: i_pop_TaskFIFO[i] high with o_TaskFIFO_empty[i] low at edge N SHALL present the head entry on o_TaskFIFO_data[i] after edge N, and SHALL advance the read pointer and decrement the count.
REQ-023 A pop while empty SHALL be ignored; o_TaskFIFO_data[i] SHALL hold its previous value.
REQ-024 o_TaskFIFO_data[i] SHALL hold its value until the next accepted pop.
REQ-025 Simultaneous write and pop on the same non-empty level SHALL leave the count unchanged and perform both operations.
REQ-026 On an empty level, a same-cycle write and pop SHALL perform the write only; the pop SHALL be dropped.
REQ-027 When a FIFO is full, ingress to that level SHALL stall even if a pop occurs in the same cycle.
REQ-028 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH.
REQ-029 The FIFOs SHALL be independent; a stall on one level SHALL NOT affect pops on any level.

Reset
REQ-030 While i_arst_n is low: all pointers and counts = 0, o_TaskFIFO_empty = all ones, o_TaskFIFO_data = 0, o_level_err = 0, o_task_ready = 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued tasks immediately; the first write is accepted at the first edge after deassertion.

Configuration
REQ-032 Macro TASK_FIFO_HWM_EN: when defined, the block SHALL add output o_fifo_hwm ($clog2(DEPTH+1) x LEVEL), the maximum count reached per level since reset, updated one cycle after each count change and reset to 0.
REQ-033 When TASK_FIFO_HWM_EN is undefined, the o_fifo_hwm port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Write 3 tasks to level 2 (data 0x11, 0x22, 0x33), then pop 3 times -> o_TaskFIFO_data[2] shows 0x11, 0x22, 0x33, each one cycle after its pop; empty[2] rises after the third pop.
REQ-035 With DEPTH=8, write 8 tasks to level 0 -> count[0]=8 and ready=0 for level 0; a pop plus a write in the same cycle -> write stalls and count becomes 7.
REQ-036 Write a pop task {type 0, treeId 3, data 0xABCD} -> stored and dequeued data field = 0x0000, type 0, treeId 3.
REQ-037 Level 1 empty, write plus pop in the same cycle -> the following cycle count[1]=1, empty[1]=0 and o_TaskFIFO_data[1] unchanged.
REQ-038 With LEVEL=3, write to level 3 -> ready=1, no count changes, and o_level_err=1 from the next cycle on.
REQ-039 Fill level 3 with 5 entries, assert reset for 1 cycle -> count[3]=0, empty=all ones, data=0; with TASK_FIFO_HWM_EN defined, hwm[3]=5 before reset and 0 after.

Source files
------------

// File: rtl/task_fifo_bank_if.sv
// task_fifo_bank_if
// Bundles the task ingress handshake and the per-level dequeue bus of the
// task FIFO bank.
//   slave  : the FIFO bank side (receives tasks and pops, drives FIFO outputs)
//   master : the producer/distributor side
// Signals:
//   i_task_valid/o_task_ready           ingress handshake
//   i_task_level/type/treeId/data       ingress task fields
//   i_pop_TaskFIFO[LEVEL]               per-level dequeue request
//   o_TaskFIFO_data[LEVEL]              dequeued entry {type, treeId, data}
//   o_TaskFIFO_empty[LEVEL]             per-level empty
//   o_fifo_count[LEVEL]                 per-level occupancy
//   o_level_err                         sticky illegal-level flag
//   o_fifo_hwm[LEVEL]                   high-water mark (only with TASK_FIFO_HWM_EN)
interface task_fifo_bank_if #(
    parameter int PTW      = 16,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4,
    parameter int DEPTH    = 8
);
    localparam int TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int LVL_BITS      = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int CNT_W         = $clog2(DEPTH + 1);
    localparam int ENT_W         = PTW + TREE_NUM_BITS + 1;

    logic                             i_task_valid;
    logic                             o_task_ready;
    logic [LVL_BITS-1:0]              i_task_level;
    logic                             i_task_type;
    logic [TREE_NUM_BITS-1:0]         i_task_treeId;
    logic [PTW-1:0]                   i_task_data;
    logic [LEVEL-1:0]                 i_pop_TaskFIFO;
    logic [LEVEL-1:0][ENT_W-1:0]      o_TaskFIFO_data;
    logic [LEVEL-1:0]                 o_TaskFIFO_empty;
    logic [LEVEL-1:0][CNT_W-1:0]      o_fifo_count;
    logic                             o_level_err;
`ifdef TASK_FIFO_HWM_EN
    logic [LEVEL-1:0][CNT_W-1:0]      o_fifo_hwm;
`endif

    modport slave (
        input  i_task_valid, i_task_level, i_task_type, i_task_treeId, i_task_data,
        input  i_pop_TaskFIFO,
        output o_task_ready, o_TaskFIFO_data, o_TaskFIFO_empty, o_fifo_count,
`ifdef TASK_FIFO_HWM_EN
        output o_fifo_hwm,
`endif
        output o_level_err
    );

    modport master (
        output i_task_valid, i_task_level, i_task_type, i_task_treeId, i_task_data,
        output i_pop_TaskFIFO,
        input  o_task_ready, o_TaskFIFO_data, o_TaskFIFO_empty, o_fifo_count,
`ifdef TASK_FIFO_HWM_EN
        input  o_fifo_hwm,
`endif
        input  o_level_err
    );
endinterface

// File: rtl/task_fifo_bank.sv
// task_fifo_bank
// One task FIFO per RPU level. Ingress tasks are steered to the FIFO named by
// their level; each level is dequeued independently by the task distributor
// with a one-cycle registered read.
// Ports:
//   i_clk      rising-edge clock
//   i_arst_n   asynchronous active-low reset
//   bus        task_fifo_bank_if.slave (ingress handshake, pops, FIFO outputs)
// Optional feature: define TASK_FIFO_HWM_EN to add per-level high-water marks
// on bus.o_fifo_hwm.
module task_fifo_bank #(
    parameter int PTW      = 16,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4,
    parameter int DEPTH    = 8
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    task_fifo_bank_if.slave     bus
);
    localparam int TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int LVL_BITS      = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int PTR_W         = $clog2(DEPTH);
    localparam int CNT_W         = $clog2(DEPTH + 1);
    localparam int ENT_W         = PTW + TREE_NUM_BITS + 1;

    logic [ENT_W-1:0]             mem_r [LEVEL][DEPTH];
    logic [LEVEL-1:0][PTR_W-1:0]  wrPtr_r;
    logic [LEVEL-1:0][PTR_W-1:0]  rdPtr_r;
    logic [LEVEL-1:0][CNT_W-1:0]  count_r;
    logic [LEVEL-1:0]             empty_r;
    logic [LEVEL-1:0][ENT_W-1:0]  dataOut_r;
    logic                         levelErr_r;

    logic [LEVEL-1:0]             full_s;
    logic [LEVEL-1:0]             wrEn_s;
    logic [LEVEL-1:0]             popEn_s;
    logic [LEVEL-1:0][CNT_W-1:0]  cntNext_s;
    logic                         levelLegal_s;
    logic                         levelReady_s;
    logic                         ready_s;
    logic                         accept_s;
    logic [ENT_W-1:0]             wrEntry_s;

    // Per-level full flags and the ingress ready for the addressed level
    always_comb begin
        levelLegal_s = 1'b0;
        levelReady_s = 1'b1;  // illegal levels are always accepted (and dropped)
        for (int i = 0; i < LEVEL; i++) begin
            full_s[i] = (count_r[i] == CNT_W'(DEPTH));
            if (bus.i_task_level == LVL_BITS'(i)) begin
                levelLegal_s = 1'b1;
                levelReady_s = ~full_s[i];
            end else begin
                levelLegal_s = levelLegal_s;
                levelReady_s = levelReady_s;
            end
        end
        // ready is held low while reset is applied
        ready_s  = i_arst_n & levelReady_s;
        accept_s = bus.i_task_valid & ready_s;
    end

    // Write/pop enables, next counts and the entry to store
    always_comb begin
        // pop tasks carry no payload; their data field is stored as zero
        if (bus.i_task_type) begin
            wrEntry_s = {bus.i_task_type, bus.i_task_treeId, bus.i_task_data};
        end else begin
            wrEntry_s = {bus.i_task_type, bus.i_task_treeId, {PTW{1'b0}}};
        end
        for (int i = 0; i < LEVEL; i++) begin
            wrEn_s[i]    = accept_s & levelLegal_s & (bus.i_task_level == LVL_BITS'(i));
            // pops use registered emptiness, so a same-cycle write to an
            // empty level cannot be read out in that cycle
            popEn_s[i]   = bus.i_pop_TaskFIFO[i] & ~empty_r[i];
            cntNext_s[i] = count_r[i] + CNT_W'(wrEn_s[i]) - CNT_W'(popEn_s[i]);
        end
    end

    // Pointers, counts, empty flags, read data and the sticky level error
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wrPtr_r    <= '0;
            rdPtr_r    <= '0;
            count_r    <= '0;
            empty_r    <= '1;
            dataOut_r  <= '0;
            levelErr_r <= 1'b0;
        end else begin
            for (int i = 0; i < LEVEL; i++) begin
                if (wrEn_s[i]) begin
                    wrPtr_r[i] <= wrPtr_r[i] + PTR_W'(1);
                end else begin
                    wrPtr_r[i] <= wrPtr_r[i];
                end
                if (popEn_s[i]) begin
                    rdPtr_r[i]   <= rdPtr_r[i] + PTR_W'(1);
                    dataOut_r[i] <= mem_r[i][rdPtr_r[i]];
                end else begin
                    rdPtr_r[i]   <= rdPtr_r[i];
                    dataOut_r[i] <= dataOut_r[i];
                end
                count_r[i] <= cntNext_s[i];
                empty_r[i] <= (cntNext_s[i] == CNT_W'(0));
            end
            if (accept_s && !levelLegal_s) begin
                levelErr_r <= 1'b1;
            end else begin
                levelErr_r <= levelErr_r;
            end
        end
    end

    // Entry storage; contents need no reset because pointers/counts guard reads
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LEVEL; i++) begin
            if (wrEn_s[i]) begin
                mem_r[i][wrPtr_r[i]] <= wrEntry_s;
            end
        end
    end

`ifdef TASK_FIFO_HWM_EN
    logic [LEVEL-1:0][CNT_W-1:0] hwm_r;

    // High-water mark trails the registered count by one cycle
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            hwm_r <= '0;
        end else begin
            for (int i = 0; i < LEVEL; i++) begin
                if (count_r[i] > hwm_r[i]) begin
                    hwm_r[i] <= count_r[i];
                end else begin
                    hwm_r[i] <= hwm_r[i];
                end
            end
        end
    end

    assign bus.o_fifo_hwm = hwm_r;
`endif

    assign bus.o_task_ready     = ready_s;
    assign bus.o_TaskFIFO_data  = dataOut_r;
    assign bus.o_TaskFIFO_empty = empty_r;
    assign bus.o_fifo_count     = count_r;
    assign bus.o_level_err      = levelErr_r;
endmodule

// File: tb/tb_task_fifo_bank.sv
// tb_task_fifo_bank
// Directed bench for task_fifo_bank. Instance A uses the default parameters
// (LEVEL=4, DEPTH=8); instance B uses LEVEL=3 so that level 3 is illegal.
module tb_task_fifo_bank;
    logic clk;
    logic rst_n;
    int   nCmp;
    int   nErr;

    task_fifo_bank_if #(.PTW(16), .LEVEL(4), .TREE_NUM(4), .DEPTH(8)) ifA ();
    task_fifo_bank_if #(.PTW(16), .LEVEL(3), .TREE_NUM(4), .DEPTH(8)) ifB ();

    task_fifo_bank #(.PTW(16), .LEVEL(4), .TREE_NUM(4), .DEPTH(8)) dutA (
        .i_clk(clk), .i_arst_n(rst_n), .bus(ifA.slave)
    );
    task_fifo_bank #(.PTW(16), .LEVEL(3), .TREE_NUM(4), .DEPTH(8)) dutB (
        .i_clk(clk), .i_arst_n(rst_n), .bus(ifB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on instance A, then return inputs to idle
    task automatic stepA(input logic v, input logic [1:0] lvl, input logic typ,
                         input logic [1:0] tree, input logic [15:0] d, input logic [3:0] pop);
        ifA.i_task_valid   = v;
        ifA.i_task_level   = lvl;
        ifA.i_task_type    = typ;
        ifA.i_task_treeId  = tree;
        ifA.i_task_data    = d;
        ifA.i_pop_TaskFIFO = pop;
        tick();
        ifA.i_task_valid   = 1'b0;
        ifA.i_pop_TaskFIFO = 4'b0000;
    endtask

    initial begin
        nCmp = 0;
        nErr = 0;
        rst_n = 1'b0;
        ifA.i_task_valid = 1'b0; ifA.i_task_level = 2'd0; ifA.i_task_type = 1'b0;
        ifA.i_task_treeId = 2'd0; ifA.i_task_data = 16'h0000; ifA.i_pop_TaskFIFO = 4'b0000;
        ifB.i_task_valid = 1'b0; ifB.i_task_level = 2'd0; ifB.i_task_type = 1'b0;
        ifB.i_task_treeId = 2'd0; ifB.i_task_data = 16'h0000; ifB.i_pop_TaskFIFO = 3'b000;

        // Reset state
        tick();
        tick();
        check("rst_count", 32'(ifA.o_fifo_count), 32'h0);
        check("rst_empty", 32'(ifA.o_TaskFIFO_empty), 32'hF);
        check("rst_data2", 32'(ifA.o_TaskFIFO_data[2]), 32'h0);
        check("rst_err", 32'(ifA.o_level_err), 32'h0);
        check("rst_ready", 32'(ifA.o_task_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(ifA.o_task_ready), 32'h1);

        // Three writes to level 2, then three pops in order
        stepA(1'b1, 2'd2, 1'b1, 2'd1, 16'h0011, 4'b0000);
        check("l2_count_1", 32'(ifA.o_fifo_count[2]), 32'd1);
        stepA(1'b1, 2'd2, 1'b1, 2'd1, 16'h0022, 4'b0000);
        stepA(1'b1, 2'd2, 1'b1, 2'd1, 16'h0033, 4'b0000);
        check("l2_count_3", 32'(ifA.o_fifo_count[2]), 32'd3);
        check("l2_not_empty", 32'(ifA.o_TaskFIFO_empty[2]), 32'h0);
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0100);
        check("l2_pop1", 32'(ifA.o_TaskFIFO_data[2]), 32'h50011);
        check("l2_count_2", 32'(ifA.o_fifo_count[2]), 32'd2);
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0100);
        check("l2_pop2", 32'(ifA.o_TaskFIFO_data[2]), 32'h50022);
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0100);
        check("l2_pop3", 32'(ifA.o_TaskFIFO_data[2]), 32'h50033);
        check("l2_empty", 32'(ifA.o_TaskFIFO_empty[2]), 32'h1);
        // pop while empty is ignored and data holds
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0100);
        check("l2_pop_empty_hold", 32'(ifA.o_TaskFIFO_data[2]), 32'h50033);
        check("l2_pop_empty_cnt", 32'(ifA.o_fifo_count[2]), 32'd0);

        // Write plus pop on empty level 1: write only
        stepA(1'b1, 2'd1, 1'b1, 2'd2, 16'h0055, 4'b0010);
        check("l1_wp_count", 32'(ifA.o_fifo_count[1]), 32'd1);
        check("l1_wp_empty", 32'(ifA.o_TaskFIFO_empty[1]), 32'h0);
        check("l1_wp_data", 32'(ifA.o_TaskFIFO_data[1]), 32'h0);
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0010);
        check("l1_pop", 32'(ifA.o_TaskFIFO_data[1]), 32'h60055);
        check("l1_empty", 32'(ifA.o_TaskFIFO_empty[1]), 32'h1);

        // Pop-type task stores a zero payload
        stepA(1'b1, 2'd1, 1'b0, 2'd3, 16'hABCD, 4'b0000);
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0010);
        check("poptask_entry", 32'(ifA.o_TaskFIFO_data[1]), 32'h30000);

        // Fill level 0
        for (int k = 0; k < 8; k++) begin
            stepA(1'b1, 2'd0, 1'b1, 2'd0, 16'h0100 + 16'(k), 4'b0000);
        end
        check("l0_full_count", 32'(ifA.o_fifo_count[0]), 32'd8);
        ifA.i_task_level = 2'd0;
        #1;
        check("l0_full_ready", 32'(ifA.o_task_ready), 32'h0);
        ifA.i_task_level = 2'd1;
        #1;
        check("l1_ready_indep", 32'(ifA.o_task_ready), 32'h1);
        tick();
        // full: write stalls even with a same-cycle pop
        stepA(1'b1, 2'd0, 1'b1, 2'd0, 16'h0200, 4'b0001);
        check("l0_full_wp_count", 32'(ifA.o_fifo_count[0]), 32'd7);
        check("l0_full_wp_data", 32'(ifA.o_TaskFIFO_data[0]), 32'h40100);
        // non-empty, not full: write and pop both happen
        stepA(1'b1, 2'd0, 1'b1, 2'd0, 16'h01FF, 4'b0001);
        check("l0_wp_count", 32'(ifA.o_fifo_count[0]), 32'd7);
        check("l0_wp_data", 32'(ifA.o_TaskFIFO_data[0]), 32'h40101);
        for (int k = 0; k < 6; k++) begin
            stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0001);
            check("l0_drain", 32'(ifA.o_TaskFIFO_data[0]), 32'h40102 + 32'(k));
        end
        // this entry was written after the write pointer wrapped
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b0001);
        check("l0_wrap_data", 32'(ifA.o_TaskFIFO_data[0]), 32'h401FF);
        check("l0_drained_empty", 32'(ifA.o_TaskFIFO_empty[0]), 32'h1);

        // Illegal level on instance B (LEVEL=3)
        ifB.i_task_valid = 1'b1;
        ifB.i_task_level = 2'd3;
        ifB.i_task_type  = 1'b1;
        ifB.i_task_data  = 16'h1234;
        #1;
        check("b_illegal_ready", 32'(ifB.o_task_ready), 32'h1);
        check("b_err_before", 32'(ifB.o_level_err), 32'h0);
        tick();
        ifB.i_task_valid = 1'b0;
        check("b_err_set", 32'(ifB.o_level_err), 32'h1);
        check("b_counts", 32'(ifB.o_fifo_count), 32'h0);
        ifB.i_task_valid = 1'b1;
        ifB.i_task_level = 2'd2;
        tick();
        ifB.i_task_valid = 1'b0;
        check("b_legal_count", 32'(ifB.o_fifo_count[2]), 32'd1);
        check("b_err_sticky", 32'(ifB.o_level_err), 32'h1);

        // Fill level 3 with five entries, then reset mid-operation
        for (int k = 0; k < 5; k++) begin
            stepA(1'b1, 2'd3, 1'b1, 2'd0, 16'(k + 1), 4'b0000);
        end
        check("l3_count", 32'(ifA.o_fifo_count[3]), 32'd5);
        tick();
`ifdef TASK_FIFO_HWM_EN
        check("hwm3_before", 32'(ifA.o_fifo_hwm[3]), 32'd5);
        check("hwm0_before", 32'(ifA.o_fifo_hwm[0]), 32'd8);
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(ifA.o_fifo_count), 32'h0);
        check("mid_rst_empty", 32'(ifA.o_TaskFIFO_empty), 32'hF);
        check("mid_rst_data0", 32'(ifA.o_TaskFIFO_data[0]), 32'h0);
        check("mid_rst_data1", 32'(ifA.o_TaskFIFO_data[1]), 32'h0);
        check("mid_rst_data2", 32'(ifA.o_TaskFIFO_data[2]), 32'h0);
        check("mid_rst_errB", 32'(ifB.o_level_err), 32'h0);
`ifdef TASK_FIFO_HWM_EN
        check("hwm3_after", 32'(ifA.o_fifo_hwm[3]), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        stepA(1'b1, 2'd3, 1'b1, 2'd2, 16'h0777, 4'b0000);
        check("post_rst_write", 32'(ifA.o_fifo_count[3]), 32'd1);
        stepA(1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'b1000);
        check("post_rst_pop", 32'(ifA.o_TaskFIFO_data[3]), 32'h60777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
